uart_tx_mmio: RTL and testbench
===============================

// Module: uart_tx_mmio
// PURPOSE
//  Memory-mapped UART transmitter on the CPU data bus, in the peripheral half of the
//  address space (0x80-0xFF) above RAM (0x00-0x7F). Consumes the datapath's addr/data/mw/mr
//  bus like the RAM does. Write bytes are queued in a small FIFO and serialised 8N1, LSB first.
//  Status and baud divisor are readable/writable so software can poll before writing.
// PARAMETERS
//  BASE_ADDR    8'h80  base of 4-byte register window; low 2 bits must be 0
//  FIFO_AW      2      FIFO address width; depth = 2**FIFO_AW (4)
//  DEFAULT_DIV  8'd15  reset value of BAUD_DIV; bit period = BAUD_DIV+1 clocks
// PORTS
//  clk    in     1  system clock, rising edge
//  rst    in     1  asynchronous, active-high reset
//  addr   in     8  bus address from datapath
//  data   inout  8  shared data bus; driven only during a selected read, else 8'bz
//  mw     in     1  memory write strobe (control_word[18])
//  mr     in     1  memory read strobe (control_word[17])
//  tx     out    1  serial output, idle high
//  busy   out    1  1 while FSM not IDLE or FIFO not empty
// BEHAVIOUR
//  Decode: sel = (addr & 8'hFC) == BASE_ADDR. Offsets: +0 TXDATA, +1 STATUS, +2 BAUD_DIV, +3 rsvd.
//  Writes: sampled on rising clk when sel & mw. Reads: combinational, data = reg when sel & mr & ~mw.
//  mw & mr together: write performed, bus not driven.
//  TXDATA wr: push data into FIFO. If full and no pop same cycle -> byte dropped, STATUS.ovf=1.
//  TXDATA rd: returns 8'h00. Rsvd (+3): reads 8'h00, writes ignored.
//  STATUS rd: {4'b0, ovf, busy, empty, full}. STATUS wr (any value): clears ovf.
//  BAUD_DIV r/w: new value used from next bit-counter reload; current bit not truncated.
//  BAUD_DIV=0 legal: 1 clock per bit.
//  FIFO: push and pop in same cycle always both succeed (incl. full, since pop frees a slot);
//  pointers wrap mod depth.
//  FSM states: IDLE, START, DATA, STOP. Bit counter bcnt counts 0..BAUD_DIV; bit index 0..7.
//   IDLE : tx=1. If FIFO non-empty at edge: load shift reg with head, pop,
//          bcnt=0 -> START.
//   START: tx=0. At bcnt==BAUD_DIV: bcnt=0, idx=0 -> DATA.
//   DATA : tx=shift[0]. At bcnt==BAUD_DIV: shift>>=1; idx==7 -> STOP else idx++.
//   STOP : tx=1. At bcnt==BAUD_DIV: -> IDLE (next byte may start next edge; gap = 1 clk).
//  Latency: TXDATA write at edge N with FIFO empty and IDLE -> tx falls after edge N+1.
//  Frame = 10*(BAUD_DIV+1) clocks plus 1 idle clock between back-to-back bytes.
//  tx is a registered output (no glitches).
//  Reset (any time, incl. mid-frame): tx=1, busy=0, FIFO empty, ovf=0,
//  BAUD_DIV=DEFAULT_DIV, FSM IDLE, bcnt=0, idx=0; data released to z. In-flight byte lost.
// STRUCTURE
//  Shared include (uart_defs.vh): register offsets, STATUS bit positions, FSM state encodings.
//  Address select reuses addr_detect (base_addr=BASE_ADDR, addr_mask=8'hFC).
//  One sub-module: sync_fifo (width 8, AW param; push/pop/full/empty/dout).
//  Top keeps regs, bus tristate and TX FSM.
// TESTING
//  1 Reset: rst pulse -> tx=1, busy=0, read 0x81 = 8'h02, read 0x82 = 8'h0F, data=z when idle.
//  2 DIV=1, write 0x80=8'hA5 -> after 1 clk tx=0 for 2 clks, then bits 1,0,1,0,0,1,0,1
//    each 2 clks, stop 1 for 2 clks; busy falls after STOP.
//  3 Write 6 bytes back-to-back at DIV=3 -> first pops at once, next 4 fill FIFO (full=1),
//    6th dropped, STATUS=8'h0D (ovf,busy,full); 5 frames on tx; wr 0x81 clears ovf.
//  4 Push while full in same cycle as FSM pop -> accepted, ovf stays 0, all bytes emitted in order.
//  5 Change BAUD_DIV 3->7 mid-DATA -> current bit stays 4 clks, following bits 8 clks.
//  6 Assert rst mid-DATA -> tx=1 immediately, FIFO empty, no further frame; RAM address
//    0x7F accesses leave this block undriven.

Source files
------------

// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, TX FSM encoding and the address-window decoder.
package uart_tx_mmio_pkg;

  localparam logic [1:0] OFS_TXDATA = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_BAUD   = 2'd2;
  localparam logic [1:0] OFS_RSVD   = 2'd3;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  function automatic logic addr_detect(input logic [7:0] addr,
                                       input logic [7:0] base_addr,
                                       input logic [7:0] addr_mask);
    return ((addr & addr_mask) == base_addr);
  endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Small synchronous FIFO; a pop frees a slot in the same cycle, so push and
// pop together always both succeed, even when full.
module uart_tx_mmio_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr];

  // storage array
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register window on the CPU bus, a byte
// FIFO and a registered-output TX state machine.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'h80,
  parameter int         FIFO_AW     = 2,
  parameter logic [7:0] DEFAULT_DIV = 8'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  inout  wire  [7:0] data,
  input  logic       mw,
  input  logic       mr,
  output logic       tx,
  output logic       busy
);

  logic       w_sel, w_wr, w_rd_en, w_push, w_pop;
  logic       w_full, w_empty, w_bit_end;
  logic [1:0] w_ofs;
  logic [7:0] w_dout, w_status, w_rd_data;

  logic       r_ovf;
  logic [7:0] r_div;

  tx_state_e  r_state, w_state_n;
  logic [7:0] r_bcnt, w_bcnt_n;
  logic [7:0] r_cur_div, w_cur_div_n;
  logic [2:0] r_idx, w_idx_n;
  logic [7:0] r_shift, w_shift_n;
  logic       r_tx, w_tx_n;

  assign w_sel   = addr_detect(addr, BASE_ADDR, 8'hFC);
  assign w_ofs   = addr[1:0];
  assign w_wr    = w_sel & mw;
  assign w_rd_en = w_sel & mr & ~mw;
  assign w_push  = w_wr & (w_ofs == OFS_TXDATA);

  uart_tx_mmio_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (data),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign busy     = (r_state != S_IDLE) | ~w_empty;
  assign w_status = {4'b0000, r_ovf, busy, w_empty, w_full};
  assign tx       = r_tx;

  // combinational register read mux
  always_comb begin
    case (w_ofs)
      OFS_STATUS: w_rd_data = w_status;
      OFS_BAUD:   w_rd_data = r_div;
      default:    w_rd_data = 8'h00;
    endcase
  end

  assign data = w_rd_en ? w_rd_data : 8'bzzzz_zzzz;

  // software-visible registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_div <= DEFAULT_DIV;
    end else begin
      if (w_push & w_full & ~w_pop) begin
        r_ovf <= 1'b1;
      end else if (w_wr & (w_ofs == OFS_STATUS)) begin
        r_ovf <= 1'b0;
      end
      if (w_wr & (w_ofs == OFS_BAUD)) begin
        r_div <= data;
      end
    end
  end

  // divisor is latched per bit so a mid-bit BAUD_DIV write never truncates it
  assign w_bit_end = (r_bcnt == r_cur_div);

  // TX next-state, counters and next serial level
  always_comb begin
    w_state_n   = r_state;
    w_bcnt_n    = r_bcnt;
    w_cur_div_n = r_cur_div;
    w_idx_n     = r_idx;
    w_shift_n   = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (~w_empty) begin
          w_pop       = 1'b1;
          w_shift_n   = w_dout;
          w_bcnt_n    = 8'd0;
          w_cur_div_n = r_div;
          w_state_n   = S_START;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_bcnt_n    = 8'd0;
          w_idx_n     = 3'd0;
          w_cur_div_n = r_div;
          w_state_n   = S_DATA;
        end else begin
          w_bcnt_n = r_bcnt + 8'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_bcnt_n    = 8'd0;
          w_cur_div_n = r_div;
          w_shift_n   = {1'b0, r_shift[7:1]};
          if (r_idx == 3'd7) begin
            w_state_n = S_STOP;
          end else begin
            w_idx_n = r_idx + 3'd1;
          end
        end else begin
          w_bcnt_n = r_bcnt + 8'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_bcnt_n  = 8'd0;
          w_state_n = S_IDLE;
        end else begin
          w_bcnt_n = r_bcnt + 8'd1;
        end
      end
      default: begin
        w_bcnt_n  = 8'd0;
        w_state_n = S_IDLE;
      end
    endcase
    case (w_state_n)
      S_START: w_tx_n = 1'b0;
      S_DATA:  w_tx_n = w_shift_n[0];
      default: w_tx_n = 1'b1;
    endcase
  end

  // TX state register; tx is driven straight from a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bcnt    <= 8'd0;
      r_cur_div <= DEFAULT_DIV;
      r_idx     <= 3'd0;
      r_shift   <= 8'h00;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_n;
      r_bcnt    <= w_bcnt_n;
      r_cur_div <= w_cur_div_n;
      r_idx     <= w_idx_n;
      r_shift   <= w_shift_n;
      r_tx      <= w_tx_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio: register access, framing,
// FIFO overflow, push-on-pop when full, baud change mid-frame, reset mid-frame.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] addr = 8'h00;
  logic       mw = 1'b0;
  logic       mr = 1'b0;
  logic       tx;
  logic       busy;
  logic       drv_en = 1'b0;
  logic [7:0] drv = 8'h00;
  wire  [7:0] w_data;

  int errors = 0;
  int checks = 0;

  assign w_data = drv_en ? drv : 8'bzzzz_zzzz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (w_data[gi]);
  end

  always #5 clk = ~clk;

  uart_tx_mmio #(.BASE_ADDR(8'h80), .FIFO_AW(2), .DEFAULT_DIV(8'd15)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .data (w_data),
    .mw   (mw),
    .mr   (mr),
    .tx   (tx),
    .busy (busy)
  );

  // serial monitor: decodes frames at mid-bit, sampling on falling edges
  int         rx_div = 1;
  bit         rx_en = 1'b0;
  logic [7:0] rx_q[$];
  int         rx_ferr = 0;
  logic [7:0] rx_b;
  initial begin : rx_mon
    forever begin
      @(negedge clk);
      if (rx_en && tx === 1'b0) begin
        rx_b = 8'h00;
        repeat (rx_div / 2) @(negedge clk);
        if (tx !== 1'b0) rx_ferr++;
        for (int i = 0; i < 8; i++) begin
          repeat (rx_div + 1) @(negedge clk);
          rx_b[i] = tx;
        end
        repeat (rx_div + 1) @(negedge clk);
        if (tx !== 1'b1) rx_ferr++;
        repeat (rx_div - rx_div / 2) @(negedge clk);
        rx_q.push_back(rx_b);
      end
    end
  end

  // call at a falling edge; the write is taken on the next rising edge
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; drv = d; drv_en = 1'b1; mw = 1'b1; mr = 1'b0;
    @(negedge clk);
    mw = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    addr = a; mr = 1'b1; mw = 1'b0; drv_en = 1'b0;
    #1;
    d = w_data;
    mr = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    bus_read(8'h81, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL reset_status: got %h expected 02", d); end
    bus_read(8'h82, d);
    checks++; if (d !== 8'h0F) begin errors++; $display("FAIL reset_div: got %h expected 0f", d); end
    bus_read(8'h80, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL txdata_read: got %h expected 00", d); end
    bus_read(8'h83, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rsvd_read: got %h expected 00", d); end
    addr = 8'h81; mr = 1'b0;
    #1;
    checks++; if (w_data !== 8'hFF) begin errors++; $display("FAIL idle_undriven: got %h expected ff (pulled up)", w_data); end
    addr = 8'h82; drv = 8'h3C; drv_en = 1'b1; mw = 1'b1; mr = 1'b1;
    #1;
    checks++; if (w_data !== 8'h3C) begin errors++; $display("FAIL mw_mr_undriven: got %h expected 3c", w_data); end
    @(negedge clk);
    mw = 1'b0; mr = 1'b0; drv_en = 1'b0;
    bus_read(8'h82, d);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL mw_mr_write: got %h expected 3c", d); end
  endtask

  task automatic test_single_frame();
    logic [9:0] fr;
    fr = {1'b1, 8'hA5, 1'b0};
    @(negedge clk);
    bus_write(8'h82, 8'h01);
    bus_write(8'h80, 8'hA5);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL frame_latency: got %b expected 1", tx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy: got %b expected 1", busy); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (tx !== fr[k/2]) begin
        errors++; $display("FAIL frame_a5 cycle %0d: got %b expected %b", k, tx, fr[k/2]);
      end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy_stop: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_end: got %b expected 0", busy); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL frame_idle_tx: got %b expected 1", tx); end
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [6];
    logic [7:0] d;
    bit ok;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    @(negedge clk);
    bus_write(8'h82, 8'h03);
    rx_div = 3; rx_q.delete(); rx_ferr = 0; rx_en = 1'b1;
    for (int i = 0; i < 6; i++) bus_write(8'h80, bytes[i]);
    bus_read(8'h81, d);
    checks++; if (d !== 8'h0D) begin errors++; $display("FAIL ovf_status: got %h expected 0d", d); end
    wait_idle(600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_idle_timeout: got busy expected idle"); end
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL ovf_frames: got %0d expected 5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== bytes[i]) begin errors++; $display("FAIL ovf_byte%0d: got %h expected %h", i, rx_q[i], bytes[i]); end
    end
    checks++; if (rx_ferr != 0) begin errors++; $display("FAIL ovf_framing: got %0d expected 0", rx_ferr); end
    bus_read(8'h81, d);
    checks++; if (d !== 8'h0A) begin errors++; $display("FAIL ovf_sticky: got %h expected 0a", d); end
    bus_write(8'h81, 8'h00);
    bus_read(8'h81, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL ovf_clear: got %h expected 02", d); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] bytes [6];
    logic [7:0] d;
    bit ok;
    bytes = '{8'h01, 8'h80, 8'hC3, 8'h3C, 8'hF0, 8'h0F};
    @(negedge clk);
    bus_write(8'h82, 8'h01);
    rx_div = 1; rx_q.delete(); rx_ferr = 0;
    for (int i = 0; i < 5; i++) bus_write(8'h80, bytes[i]);
    repeat (17) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL pp_gap_tx: got %b expected 1", tx); end
    bus_read(8'h81, d);
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL pp_full_before: got %h expected 05", d); end
    bus_write(8'h80, bytes[5]);
    bus_read(8'h81, d);
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL pp_full_after: got %h expected 05", d); end
    wait_idle(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pp_idle_timeout: got busy expected idle"); end
    checks++; if (rx_q.size() != 6) begin errors++; $display("FAIL pp_frames: got %0d expected 6", rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== bytes[i]) begin errors++; $display("FAIL pp_byte%0d: got %h expected %h", i, rx_q[i], bytes[i]); end
    end
    checks++; if (rx_ferr != 0) begin errors++; $display("FAIL pp_framing: got %0d expected 0", rx_ferr); end
    bus_read(8'h81, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL pp_status_end: got %h expected 02", d); end
    rx_en = 1'b0;
  endtask

  task automatic test_baud_change();
    logic [9:0] fr;
    logic       exp_q[$];
    fr = {1'b1, 8'h5A, 1'b0};
    for (int j = 0; j < 10; j++) begin
      for (int r = 0; r < ((j < 3) ? 4 : 8); r++) exp_q.push_back(fr[j]);
    end
    @(negedge clk);
    bus_write(8'h82, 8'h03);
    bus_write(8'h80, 8'h5A);
    for (int k = 0; k < 68; k++) begin
      @(negedge clk);
      checks++;
      if (tx !== exp_q[k]) begin
        errors++; $display("FAIL baud_change cycle %0d: got %b expected %b", k, tx, exp_q[k]);
      end
      if (k == 8) begin
        addr = 8'h82; drv = 8'h07; drv_en = 1'b1; mw = 1'b1;
      end else if (k == 9) begin
        mw = 1'b0; drv_en = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL baud_change_end: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    bit bad;
    @(negedge clk);
    bus_write(8'h82, 8'h01);
    bus_write(8'h80, 8'h00);
    bus_write(8'h80, 8'hFF);
    repeat (6) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rst_pre_data: got %b expected 0", tx); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_async_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    bus_read(8'h81, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL rst_mid_status: got %h expected 02", d); end
    bus_read(8'h82, d);
    checks++; if (d !== 8'h0F) begin errors++; $display("FAIL rst_mid_div: got %h expected 0f", d); end
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL rst_no_frame: got activity expected idle line"); end
    addr = 8'h7F; mr = 1'b1;
    #1;
    checks++; if (w_data !== 8'hFF) begin errors++; $display("FAIL ram_read_undriven: got %h expected ff", w_data); end
    mr = 1'b0;
    @(negedge clk);
    bus_write(8'h7F, 8'h55);
    bus_read(8'h81, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL ram_write_ignored: got %h expected 02", d); end
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL ram_write_tx: got %b expected 1", tx); end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    test_reset();
    test_single_frame();
    test_overflow();
    test_push_pop_full();
    test_baud_change();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
